// File: rtl/byte_stripe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_stripe_ctrl
//  Description : Stripes a byte stream into lane0/lane1 pairs. Odd-length
//                packets and stalled half-pairs are completed with PAD_BYTE.
//                A single-entry output register with valid/ready backpressure
//                allows back-to-back delivery and acceptance with no bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_stripe_ctrl #(
    parameter logic [7:0]  PAD_BYTE = 8'hF7,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  lane0,
    output logic [7:0]  lane1,
    output logic        lanes_valid,
    input  logic        lanes_ready,
    output logic [15:0] pair_count,
    output logic [15:0] pad_count
);

    // Idle count at which the timeout fires: the pad pair appears in the
    // cycle right after the TIMEOUT-th idle HALF cycle.
    localparam logic [7:0] c_IDLE_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q,  hold_d;
    logic [7:0]  lane0_q, lane0_d;
    logic [7:0]  lane1_q, lane1_d;
    logic [7:0]  idle_q,  idle_d;
    logic [15:0] pair_q,  pair_d;
    logic [15:0] pad_q,   pad_d;

    logic w_accept;
    logic w_deliver;

    assign in_ready    = (state_q != S_FULL) || lanes_ready;
    assign lanes_valid = (state_q == S_FULL);
    assign lane0       = lane0_q;
    assign lane1       = lane1_q;
    assign pair_count  = pair_q;
    assign pad_count   = pad_q;

    assign w_accept  = in_valid && in_ready;
    assign w_deliver = (state_q == S_FULL) && lanes_ready;

    // State and datapath registers; reset discards any held byte or pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            hold_q  <= 8'h00;
            lane0_q <= 8'h00;
            lane1_q <= 8'h00;
            idle_q  <= 8'h00;
            pair_q  <= 16'h0000;
            pad_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            idle_q  <= idle_d;
            pair_q  <= pair_d;
            pad_q   <= pad_d;
        end
    end

    // Next-state logic: pair assembly, padding, timeout and delivery.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        idle_d  = idle_q;
        pair_d  = pair_q;
        pad_d   = pad_q;

        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    if (in_last) begin
                        lane0_d = in_data;
                        lane1_d = PAD_BYTE;
                        pad_d   = pad_q + 16'd1;
                        state_d = S_FULL;
                    end else begin
                        hold_d  = in_data;
                        idle_d  = 8'h00;
                        state_d = S_HALF;
                    end
                end
            end

            S_HALF: begin
                if (w_accept) begin
                    // Second byte completes the pair whatever in_last says.
                    lane0_d = hold_q;
                    lane1_d = in_data;
                    state_d = S_FULL;
                end else if (idle_q == c_IDLE_LAST) begin
                    lane0_d = hold_q;
                    lane1_d = PAD_BYTE;
                    pad_d   = pad_q + 16'd1;
                    state_d = S_FULL;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end

            S_FULL: begin
                if (w_deliver) begin
                    pair_d  = pair_q + 16'd1;
                    lane0_d = 8'h00;
                    lane1_d = 8'h00;
                    state_d = S_EMPTY;
                    // A byte taken in the delivery cycle is handled as if
                    // arriving in EMPTY, so the stream sees no bubble.
                    if (w_accept) begin
                        if (in_last) begin
                            lane0_d = in_data;
                            lane1_d = PAD_BYTE;
                            pad_d   = pad_q + 16'd1;
                            state_d = S_FULL;
                        end else begin
                            hold_d  = in_data;
                            idle_d  = 8'h00;
                            state_d = S_HALF;
                        end
                    end
                end
            end

            default: begin
                state_d = S_EMPTY;
                lane0_d = 8'h00;
                lane1_d = 8'h00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/byte_stripe_ctrl.md
BYTE_STRIPE_CTRL -- requirements
Module: byte_stripe_ctrl

Interface
REQ-001 Parameter PAD_BYTE, default 8'hF7, SHALL be the lane-1 filler byte for odd-length packets and for timeouts.
REQ-002 Parameter TIMEOUT, default 16, legal range 1..255, SHALL be the idle cycles allowed in HALF before a forced pad.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_data  input  8  SHALL carry the byte-stream data.
REQ-006 in_valid  input  1  SHALL be high when in_data holds a byte.
REQ-007 in_last  input  1  SHALL be high when the byte is the last of its packet; it is qualified by in_valid.
REQ-008 in_ready  output  1  SHALL be high when the block can take a byte; it is combinational.
REQ-009 lane0  output  8  SHALL carry the striped byte for lane 0.
REQ-010 lane1  output  8  SHALL carry the striped byte for lane 1.
REQ-011 lanes_valid  output  1  SHALL be high when the lane0/lane1 pair is valid.
REQ-012 lanes_ready  input  1  SHALL be high when downstream accepts the pair.
REQ-013 pair_count  output  16  SHALL count pairs delivered to downstream.
REQ-014 pad_count  output  16  SHALL count PAD_BYTE insertions.

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 A pair SHALL be delivered only in a cycle where lanes_valid=1 and lanes_ready=1.
REQ-017 The FSM SHALL have exactly three states: EMPTY (nothing held), HALF (one byte held for lane0) and FULL (pair presented).
REQ-018 in_ready SHALL be 1 in EMPTY and HALF, and SHALL equal lanes_ready in FULL.
REQ-019 lanes_valid SHALL be 1 only in FULL, and lane0/lane1 SHALL be 8'h00 whenever lanes_valid=0.
REQ-020 EMPTY, accept with in_last=0: the block SHALL hold the byte and go to HALF.
REQ-021 EMPTY, accept with in_last=1: the next cycle SHALL present lane0=byte, lane1=PAD_BYTE, enter FULL and increment pad_count.
REQ-022 HALF, accept: the next cycle SHALL present lane0=held byte, lane1=in_data and enter FULL, regardless of in_last.
REQ-023 HALF SHALL keep an idle counter that is cleared on entry to HALF and increments each HALF cycle without an accept.
REQ-024 When the idle counter reaches TIMEOUT, the next cycle SHALL present {held byte, PAD_BYTE}, enter FULL and increment pad_count.
REQ-025 FULL with lanes_ready=0: lane0, lane1 and lanes_valid SHALL hold stable and no byte SHALL be accepted.
REQ-026 FULL, deliver, no accept: pair_count SHALL increment and the state SHALL go to EMPTY.
REQ-027 FULL, deliver and accept in the same cycle: pair_count SHALL increment and the new byte SHALL be handled per REQ-020/REQ-021, going to HALF or to FULL with a pad; no bubble is allowed.
REQ-028 Latency: a pair SHALL be visible in the cycle after the byte that completes it is accepted, or in the cycle after the timeout fires.
REQ-029 pair_count and pad_count SHALL wrap from 16'hFFFF to 16'h0000 without saturating or flagging.
REQ-030 In-order: bytes SHALL appear lane0 first, then lane1, in acceptance order; bytes SHALL never be dropped or duplicated outside reset.

Reset
REQ-031 While reset=1 at a clock edge, the state SHALL become EMPTY and lane0, lane1, lanes_valid, pair_count, pad_count and the idle counter SHALL become 0.
REQ-032 Because in_ready is combinational, it SHALL read 1 in the cycle after reset; in_ready may be high while reset is asserted, but the block SHALL ignore all bytes accepted in a reset cycle.
REQ-033 Reset in HALF or FULL SHALL discard the held byte and the pending pair, with no delivery and no count change other than clearing.

Verification
REQ-034 reset=1 for 2 cycles, then 0 -> all outputs 0, in_ready=1, lanes_valid=0.
REQ-035 Send 0x11 then 0x22 on consecutive cycles, lanes_ready=1 -> the next cycle shows lane0=0x11, lane1=0x22, lanes_valid=1; one cycle later pair_count=1.
REQ-036 Send 0x33 with in_last=1 from EMPTY -> the next cycle shows lane0=0x33, lane1=0xF7 and pad_count=1.
REQ-037 Send 0x44 with in_last=0, then in_valid=0 for 16 cycles -> the following cycle shows lane0=0x44, lane1=0xF7 and pad_count increments by 1.
REQ-038 Hold FULL {0xAA,0xBB} with lanes_ready=0 for 5 cycles while 0x55 is offered -> outputs stable and in_ready=0; on raising lanes_ready, the pair is delivered and 0x55 is accepted in the same cycle (state HALF).
REQ-039 Assert reset while in HALF holding 0x66, then send 0x77 and 0x88 -> the pair is {0x77,0x88}, 0x66 never appears, and the counts restart from 0.
